// File: rtl/debounce_pkg.sv
// Shared state encoding and default qualification length for the debounce front end.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both stages clear on reset.
module sync2 (
    input  logic _clock,
    input  logic _reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge _clock) begin
        if (_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/debounce_front.sv
// Level debouncer: a new raw level is accepted after DEBOUNCE_CYCLES consecutive samples.
// Define DEBOUNCE_FRONT_SYNC_EN to put a two-flop synchronizer (sync2) ahead of the FSM.
module debounce_front
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 8
) (
    input  logic       _clock,
    input  logic       _reset,
    input  logic       raw,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic raw_s;

`ifdef DEBOUNCE_FRONT_SYNC_EN
    sync2 u_sync2 (
        ._clock (_clock),
        ._reset (_reset),
        .d_i    (raw),
        .q_o    (raw_s)
    );
`else
    assign raw_s = raw;
`endif

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LOW: begin
                if (raw_s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!raw_s) begin
                    state_d = LOW;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!raw_s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (raw_s) begin
                    state_d = HIGH;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = LOW;
        endcase
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign state = state_q;

endmodule
